// File: rtl/pc_unit_ras.sv
// Fetch PC unit with a circular return-address stack.
// The PC advances to one of five next-PC sources under an advance/stall
// handshake; link jumps push pc+4 and RETURN pops it back as the target.
module pc_unit_ras #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    input  logic [2:0]        npc_sel,
    input  logic [15:0]       offset,
    input  logic [25:0]       irrelative,
    input  logic [ADDR_W-1:0] register,
    input  logic              call,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              misalign
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_PC);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(RAS_DEPTH);

    localparam logic [2:0] SEL_RELATIVE   = 3'd1;
    localparam logic [2:0] SEL_IRRELATIVE = 3'd2;
    localparam logic [2:0] SEL_REGISTER   = 3'd3;
    localparam logic [2:0] SEL_RETURN     = 3'd4;

    logic [ADDR_W-1:0] pc_reg;
    logic              misalign_reg;
    logic [PTR_W-1:0]  top_reg;
    logic [CNT_W-1:0]  count_reg;

    // Stack entries carry no reset: an entry is only read after it was written.
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] rel_target;
    logic [ADDR_W-1:0] irr_target;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] npc_next;
    logic              push;
    logic              pop;
    logic [PTR_W-1:0]  wr_ptr;

    assign pc_plus4   = pc_reg + ADDR_W'(4);
    assign rel_target = pc_plus4 + {{(ADDR_W-18){offset[15]}}, offset, 2'b00};
    assign ras_top    = ras_mem[top_reg];

    // Region bits above the 28-bit jump field only exist for wide addresses.
    generate
        if (ADDR_W > 28) begin : g_irr_region
            assign irr_target = {pc_plus4[ADDR_W-1:28], irrelative, 2'b00};
        end else begin : g_irr_flat
            assign irr_target = {irrelative, 2'b00};
        end
    endgenerate

    assign ras_empty = (count_reg == '0);
    assign ras_full  = (count_reg == CNT_MAX);

    assign push = call;
    assign pop  = (npc_sel == SEL_RETURN) && !ras_empty;

    // A simultaneous push and pop overwrites the current top in place.
    assign wr_ptr = pop ? top_reg : top_reg + PTR_W'(1);

    // Next-PC source mux; RETURN falls back to the register operand on an empty stack.
    always_comb begin
        npc_next = pc_plus4;
        case (npc_sel)
            SEL_RELATIVE:   npc_next = rel_target;
            SEL_IRRELATIVE: npc_next = irr_target;
            SEL_REGISTER:   npc_next = register;
            SEL_RETURN:     npc_next = ras_empty ? register : ras_top;
            default:        npc_next = pc_plus4;
        endcase
    end

    // PC register: a misaligned target is rejected and flagged for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= RESET_VAL;
            misalign_reg <= 1'b0;
        end else if (adv) begin
            if (npc_next[1:0] == 2'b00) begin
                pc_reg       <= npc_next;
                misalign_reg <= 1'b0;
            end else begin
                misalign_reg <= 1'b1;
            end
        end else begin
            misalign_reg <= 1'b0;
        end
    end

    // Stack pointer and occupancy; pushing when full wraps over the oldest entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_reg   <= '0;
            count_reg <= '0;
        end else if (adv) begin
            if (push && !pop) begin
                top_reg <= top_reg + PTR_W'(1);
                if (!ras_full) begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end else if (pop && !push) begin
                top_reg   <= top_reg - PTR_W'(1);
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    // Stack entry write of the link address.
    always_ff @(posedge clk) begin
        if (adv && push) begin
            ras_mem[wr_ptr] <= pc_plus4;
        end
    end

    assign pc       = pc_reg;
    assign npc      = npc_next;
    assign misalign = misalign_reg;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Bench for pc_unit_ras: a queue-based reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_pc_unit_ras;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        adv;
    logic [2:0]  npc_sel;
    logic [15:0] offset;
    logic [25:0] irrelative;
    logic [31:0] register;
    logic        call;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        ras_empty;
    logic        ras_full;
    logic        misalign;

    int checks = 0;
    int errors = 0;
    bit tb_done = 0;

    pc_unit_ras #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_3000),
        .RAS_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (adv),
        .npc_sel   (npc_sel),
        .offset    (offset),
        .irrelative(irrelative),
        .register  (register),
        .call      (call),
        .pc        (pc),
        .npc       (npc),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .misalign  (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: the stack is a queue whose back is the top.
    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_ras[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pc  = 32'h0000_3000;
        m_mis = 1'b0;
        m_ras.delete();
    endtask

    function automatic logic [31:0] model_npc();
        logic [31:0] p4;
        p4 = m_pc + 32'd4;
        case (npc_sel)
            3'd1:    return p4 + (32'(signed'(offset)) << 2);
            3'd2:    return {p4[31:28], irrelative, 2'b00};
            3'd3:    return register;
            3'd4:    return (m_ras.size() > 0) ? m_ras[$] : register;
            default: return p4;
        endcase
    endfunction

    always @(negedge rst_n) m_reset();

    // Model step at each active edge.
    always @(posedge clk) begin
        if (rst_n) begin
            logic [31:0] t;
            logic        do_pop;
            logic [31:0] link;
            t      = model_npc();
            do_pop = (npc_sel == 3'd4) && (m_ras.size() > 0);
            link   = m_pc + 32'd4;
            if (adv) begin
                if (call && do_pop) begin
                    m_ras[m_ras.size()-1] = link;
                end else if (call) begin
                    m_ras.push_back(link);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end else if (do_pop) begin
                    void'(m_ras.pop_back());
                end
                if (t[1:0] == 2'b00) begin
                    m_pc  = t;
                    m_mis = 1'b0;
                end else begin
                    m_mis = 1'b1;
                end
            end else begin
                m_mis = 1'b0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (rst_n && !tb_done) begin
            chk("cyc_pc", pc, m_pc);
            chk("cyc_npc", npc, model_npc());
            chk("cyc_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
            chk("cyc_full", 32'(ras_full), 32'(m_ras.size() == DEPTH));
            chk("cyc_misalign", 32'(misalign), 32'(m_mis));
        end
    end

    task automatic drive(input logic a, input logic [2:0] s, input logic [15:0] o,
                         input logic [25:0] i, input logic [31:0] r, input logic c);
        adv = a; npc_sel = s; offset = o; irrelative = i; register = r; call = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        drive(0, 3'd0, 16'h0, 26'h0, 32'h0, 0);
        m_reset();
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_pc", pc, 32'h3000);
        chk("rst_empty", 32'(ras_empty), 32'd1);
        chk("rst_full", 32'(ras_full), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        rst_n = 1'b1;

        // Sequential fetch.
        drive(1, 3'd0, 16'h0, 26'h0, 32'h0, 0);
        tick(); chk("norm_1", pc, 32'h3004);
        tick(); chk("norm_2", pc, 32'h3008);
        tick(); chk("norm_3", pc, 32'h300C);
        tick(); chk("norm_4", pc, 32'h3010);

        // Backward branch and absolute jump.
        drive(1, 3'd1, 16'hFFFE, 26'h0, 32'h0, 0);
        chk("rel_npc", npc, 32'h300C);
        tick(); chk("rel_pc", pc, 32'h300C);
        drive(1, 3'd2, 16'h0, 26'h0000C10, 32'h0, 0);
        chk("irr_npc", npc, 32'h3040);
        tick();

        // Call then return, then return on empty stack.
        drive(1, 3'd3, 16'h0, 26'h0, 32'h3000, 0);
        tick(); chk("reg_pc", pc, 32'h3000);
        drive(1, 3'd2, 16'h0, 26'h0000C40, 32'h0, 1);
        chk("call_npc", npc, 32'h3100);
        tick(); chk("call_pc", pc, 32'h3100);
        chk("call_nonempty", 32'(ras_empty), 32'd0);
        drive(1, 3'd4, 16'h0, 26'h0, 32'hDEAD_BEE0, 0);
        chk("ret_npc", npc, 32'h3004);
        tick(); chk("ret_pc", pc, 32'h3004);
        chk("ret_empty", 32'(ras_empty), 32'd1);
        chk("ret_fallback_npc", npc, 32'hDEAD_BEE0);
        tick(); chk("ret_fallback_pc", pc, 32'hDEAD_BEE0);

        // Five pushes into a four-deep stack, then four pops.
        drive(1, 3'd3, 16'h0, 26'h0, 32'h3000, 0);
        tick();
        drive(1, 3'd0, 16'h0, 26'h0, 32'h0, 1);
        for (int k = 0; k < 5; k++) begin
            #1;
            if (k == 4) chk("push5_full_during", 32'(ras_full), 32'd1);
            tick();
        end
        chk("push5_full_after", 32'(ras_full), 32'd1);
        drive(1, 3'd4, 16'h0, 26'h0, 32'h0, 0);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_l;
            exp_l = 32'h3014 - 32'(k) * 32'd4;
            chk("pop_npc", npc, exp_l);
            tick();
            #1;
        end
        chk("pop_empty", 32'(ras_empty), 32'd1);
        chk("pop_pc", pc, 32'h3008);

        // Misaligned register target, with and without advance.
        drive(1, 3'd3, 16'h0, 26'h0, 32'h3002, 0);
        tick();
        chk("mis_pc_hold", pc, 32'h3008);
        chk("mis_pulse", 32'(misalign), 32'd1);
        drive(0, 3'd3, 16'h0, 26'h0, 32'h3002, 0);
        tick();
        chk("mis_clear", 32'(misalign), 32'd0);
        tick();
        chk("mis_stall_pc", pc, 32'h3008);
        chk("mis_stall_flag", 32'(misalign), 32'd0);

        // Build three entries at pc 0x3200, then reset mid-cycle.
        drive(1, 3'd3, 16'h0, 26'h0, 32'h31F4, 0);
        tick();
        drive(1, 3'd0, 16'h0, 26'h0, 32'h0, 1);
        tick(); tick(); tick();
        chk("pre_rst_pc", pc, 32'h3200);
        drive(0, 3'd0, 16'h0, 26'h0, 32'h0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_pc", pc, 32'h3000);
        chk("async_empty", 32'(ras_empty), 32'd1);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("stall_pc", pc, 32'h3000);
        chk("stall_empty", 32'(ras_empty), 32'd1);
        chk("stall_misalign", 32'(misalign), 32'd0);

        tb_done = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
- Next-generation fetch PC unit for the MIPS core: owns the architectural PC register, computes the next PC from one of five selectable sources and advances it under a stall handshake.
- Adds a parametrised return-address stack (RAS) so call/return pairs resolve without the register-file value.
- Sits between decode (select, offset, index and register operands) and instruction memory (drives the fetch address).

Parameters:
- ADDR_W, 32, PC/address width; must be ≥ 28.
- RESET_PC, 32'h0000_3000, PC value loaded on reset. Truncated to ADDR_W.
- RAS_DEPTH, 4, number of RAS entries; a power of two, 2..16.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  asynchronous active-low reset.
- adv  in  1  advance enable. 1 = PC loads npc this edge; 0 = stall, all state holds.
- npc_sel  in  3  source select: 0 NORM, 1 RELATIVE, 2 IRRELATIVE, 3 REGISTER, 4 RETURN. Codes 5..7 are treated as NORM.
- offset  in  16  signed branch word offset.
- irrelative  in  26  jump instruction index.
- register  in  ADDR_W  register-file jump target.
- call  in  1  current instruction is a link jump (jal/jalr); pushes the link address.
- pc  out  ADDR_W  current fetch address (registered).
- npc  out  ADDR_W  combinational next PC.
- ras_empty  out  1  RAS holds 0 valid entries.
- ras_full  out  1  RAS holds RAS_DEPTH valid entries.
- misalign  out  1  registered one-cycle pulse: the last attempted target had a nonzero value in bits [1:0].

Behaviour:
- Reset (async, rst_n=0):
  - pc = RESET_PC.
  - RAS count = 0 and top pointer = 0.
  - misalign = 0, so ras_empty = 1 and ras_full = 0.
  - Entry contents are don't-care.
  - Assertion mid-operation clears state immediately, with no clock edge required.
- Sources, all arithmetic modulo 2^ADDR_W:
  - NORM: pc+4.
  - RELATIVE: pc+4+(sign-extended offset<<2).
  - IRRELATIVE: {bits [ADDR_W-1:28] of pc+4, irrelative, 2'b00}.
  - REGISTER: register.
  - RETURN: RAS top entry if ras_empty=0; otherwise register (fallback).
- npc is purely combinational from the current pc, the inputs and the RAS top; it is valid even when adv=0.
- Update at posedge with adv=1:
  - If npc[1:0]==0, pc<=npc and misalign<=0.
  - Otherwise pc holds and misalign<=1.
  - The RAS ops below still occur in either case.
- Posedge with adv=0: pc, RAS and count hold; misalign<=0.
- RAS ops, only at a posedge with adv=1. Link value = pc+4. Pop = (npc_sel==RETURN && !ras_empty).
  - Push only: top<=top+1 mod RAS_DEPTH; entry[new top]<=link; count<=min(count+1, RAS_DEPTH).
  - Push when full: circular overwrite of the oldest entry; count stays at RAS_DEPTH; no error.
  - Pop only: top<=top-1 mod RAS_DEPTH; count<=count-1.
  - RETURN with ras_empty=1: no pop; uses the register fallback.
  - Push and pop together: entry[top]<=link; top and count unchanged (net replace).
- Latency: one cycle from select to pc; RAS top reflects a push on the following cycle.
- ras_empty/ras_full are decoded combinationally from the registered count.

Test Plan:
- Reset release, adv=1, npc_sel=NORM for 3 cycles -> pc sequence 0x3000, 0x3004, 0x3008, 0x300C.
- pc=0x3010, RELATIVE offset=16'hFFFE -> npc=0x300C. Then IRRELATIVE irrelative=26'h0000C10 at pc=0x300C -> npc=0x0000_3040.
- pc=0x3000, call=1, IRRELATIVE to 0x3100, then RETURN with register=0xDEAD_BEE0:
  - The pop cycle shows npc=0x3004 (RAS wins).
  - ras_empty returns to 1.
  - A second RETURN yields 0xDEAD_BEE0.
- RAS_DEPTH=4: five consecutive pushes with links L1..L5 -> ras_full=1 throughout the fifth. Four pops return L5, L4, L3, L2; ras_empty=1 afterwards.
- REGISTER target 0x3002 with adv=1 -> pc holds and misalign=1 for exactly one cycle. The same input with adv=0 -> misalign stays 0 and pc holds.
- Async reset: rst_n=0 mid-cycle with count=3 and pc=0x3200 -> pc=0x3000 and ras_empty=1 before the next edge; adv=0 held for 2 cycles -> no state change.
